// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: owns the 256-mclk frame counter, captures one L/R pair per frame, shifts it out MSB-first.
// Latency: sample captured on the cnt 255->0 edge; left MSB on sdata at cnt 4..7, right MSB at cnt 132..135.
// Backpressure: none; the producer must present samples by cnt=255, otherwise underrun is counted and zeros go out.
module i2s_tx_serializer #(
  parameter int SAMPLE_BITS   = 16,
  parameter int UNDERRUN_BITS = 16
) (
  input  logic                     mclk,
  input  logic                     rst,
  input  logic [SAMPLE_BITS-1:0]   sample_l,
  input  logic [SAMPLE_BITS-1:0]   sample_r,
  input  logic                     sample_valid,
  input  logic                     mute,
  output logic [7:0]               m_sample_index,
  output logic                     frame_start,
  output logic                     bclk,
  output logic                     lrclk,
  output logic                     sdata,
  output logic [UNDERRUN_BITS-1:0] underrun_cnt
);

  logic [7:0]             r_cnt;
  logic [SAMPLE_BITS-1:0] r_hold_l;
  logic [SAMPLE_BITS-1:0] r_hold_r;

  logic [7:0]             w_cnt_nxt;
  logic                   w_capture;
  logic                   w_load_inputs;
  logic [SAMPLE_BITS-1:0] w_hold_l_nxt;
  logic [SAMPLE_BITS-1:0] w_hold_r_nxt;
  logic [4:0]             w_k5;
  logic [4:0]             w_idx;
  logic [31:0]            w_slot;
  logic                   w_sdata_nxt;
  logic                   w_und_inc;

  assign m_sample_index = r_cnt;
  assign w_cnt_nxt      = r_cnt + 8'd1;

  // The capture edge is the one taking cnt from 255 to 0.
  assign w_capture     = (r_cnt == 8'hFF);
  assign w_load_inputs = w_capture && !mute && sample_valid;
  assign w_und_inc     = w_capture && !mute && !sample_valid && !(&underrun_cnt);

  // Next hold contents: mute and underrun both force silence for the coming frame.
  always_comb begin
    w_hold_l_nxt = r_hold_l;
    w_hold_r_nxt = r_hold_r;
    if (w_capture) begin
      w_hold_l_nxt = w_load_inputs ? sample_l : '0;
      w_hold_r_nxt = w_load_inputs ? sample_r : '0;
    end
  end

  // Serial bit for the next count. Each word sits MSB-first in a 32-bit slot with
  // zero padding below it; slot bit 0 is never sent because period 0 of each half
  // is the one-BCLK I2S delay. Bit position within the slot is 32-k (mod 32).
  assign w_k5        = w_cnt_nxt[6:2];
  assign w_idx       = 5'd0 - w_k5;
  assign w_slot      = {(w_cnt_nxt[7] ? w_hold_r_nxt : w_hold_l_nxt), {(32-SAMPLE_BITS){1'b0}}};
  assign w_sdata_nxt = (w_k5 != 5'd0) && w_slot[w_idx];

  // Frame counter and hold registers; the hold pair only moves at the capture edge.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 8'd0;
      r_hold_l <= '0;
      r_hold_r <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_hold_l <= w_hold_l_nxt;
      r_hold_r <= w_hold_r_nxt;
    end
  end

  // Serial outputs registered from next-count logic so they line up with cnt exactly.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b1;
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
    end else begin
      frame_start <= (w_cnt_nxt == 8'd0);
      bclk        <= w_cnt_nxt[1];
      lrclk       <= w_cnt_nxt[7];
      sdata       <= w_sdata_nxt;
    end
  end

  // Saturating count of captures that found no valid sample while unmuted.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (w_und_inc) begin
      underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
module tb_i2s_tx_serializer;

  localparam int SB = 16;

  logic        mclk = 1'b0;
  logic        rst;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_valid;
  logic        mute;

  logic [7:0]  idx_a, idx_b;
  logic        fs_a, fs_b, bclk_a, bclk_b, lr_a, lr_b, sd_a, sd_b;
  logic [15:0] und_a;
  logic [1:0]  und_b;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // reference model state
  int unsigned m_cnt;
  int unsigned m_l, m_r;
  int unsigned m_und_a, m_und_b;

  always #5 mclk = ~mclk;

  i2s_tx_serializer #(.SAMPLE_BITS(16), .UNDERRUN_BITS(16)) u_dut (
    .mclk(mclk), .rst(rst), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .mute(mute), .m_sample_index(idx_a),
    .frame_start(fs_a), .bclk(bclk_a), .lrclk(lr_a), .sdata(sd_a), .underrun_cnt(und_a)
  );

  i2s_tx_serializer #(.SAMPLE_BITS(16), .UNDERRUN_BITS(2)) u_dut_sat (
    .mclk(mclk), .rst(rst), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .mute(mute), .m_sample_index(idx_b),
    .frame_start(fs_b), .bclk(bclk_b), .lrclk(lr_b), .sdata(sd_b), .underrun_cnt(und_b)
  );

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cnt=%0d observed=%0h expected=%0h", tag, m_cnt, obs, exp);
    end
  endtask

  // Serial bit straight from the frame layout: one BCLK delay, MSB first, zero fill.
  function automatic int unsigned exp_sdata(input int unsigned c);
    int unsigned k;
    k = c / 4;
    if (k >= 1 && k <= SB)           return (m_l >> (SB - k)) & 1;
    if (k >= 33 && k <= 32 + SB)     return (m_r >> (SB + 32 - k)) & 1;
    return 0;
  endfunction

  task automatic check_all();
    int unsigned e_fs, e_bclk, e_lr, e_sd;
    e_fs   = (m_cnt == 0) ? 1 : 0;
    e_bclk = (m_cnt / 2) % 2;
    e_lr   = m_cnt / 128;
    e_sd   = exp_sdata(m_cnt);
    check_val("index",     idx_a,  m_cnt);
    check_val("frame_start", fs_a, e_fs);
    check_val("bclk",      bclk_a, e_bclk);
    check_val("lrclk",     lr_a,   e_lr);
    check_val("sdata",     sd_a,   e_sd);
    check_val("underrun",  und_a,  m_und_a);
    check_val("sat_index", idx_b,  m_cnt);
    check_val("sat_fs",    fs_b,   e_fs);
    check_val("sat_bclk",  bclk_b, e_bclk);
    check_val("sat_lrclk", lr_b,   e_lr);
    check_val("sat_sdata", sd_b,   e_sd);
    check_val("sat_underrun", und_b, m_und_b);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_l = 0; m_r = 0; m_und_a = 0; m_und_b = 0;
  endtask

  // Model update for one rising mclk edge, using the inputs as the DUT saw them.
  task automatic model_edge();
    if (rst) return;
    if (m_cnt == 255) begin
      if (mute) begin
        m_l = 0; m_r = 0;
      end else if (!sample_valid) begin
        m_l = 0; m_r = 0;
        if (m_und_a < 65535) m_und_a++;
        if (m_und_b < 3)     m_und_b++;
      end else begin
        m_l = sample_l; m_r = sample_r;
      end
    end
    m_cnt = (m_cnt + 1) % 256;
  endtask

  // Called just after a falling edge: check, cross the rising edge, return at the next falling edge.
  task automatic step();
    check_all();
    @(posedge mclk);
    model_edge();
    @(negedge mclk);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int unsigned c);
    for (int i = 0; i < 256 && m_cnt != c; i++) step();
    check_val("reach_cnt", m_cnt, c);
  endtask

  initial begin
    rst = 1'b1; sample_l = '0; sample_r = '0; sample_valid = 1'b0; mute = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge mclk);
    run_cycles(3);
    rst = 1'b0;

    // free run, no valid samples: frame 0 silent, underruns start at end of frame 0
    run_cycles(512);

    // fixed pattern
    sample_l = 16'hA5F0; sample_r = 16'h0F0F; sample_valid = 1'b1;
    run_cycles(512);

    // capture window: a change mid-frame only lands at the next capture
    sample_l = 16'h1234;
    run_until(0);
    run_until(10);
    sample_l = 16'hFFFF;
    run_cycles(512);

    // underrun for 3 frames, then mute with valid low for 2 frames
    run_until(100);
    sample_valid = 1'b0;
    run_cycles(768);
    mute = 1'b1;
    run_cycles(512);
    mute = 1'b0; sample_valid = 1'b1;

    // randomized frames with input changes at random points
    for (int f = 0; f < 14; f++) begin
      run_until($urandom_range(0, 255));
      sample_l     = 16'($urandom);
      sample_r     = 16'($urandom);
      sample_valid = ($urandom_range(0, 3) != 0);
      mute         = ($urandom_range(0, 5) == 0);
      run_cycles($urandom_range(1, 300));
    end

    // reset in the middle of a frame while streaming
    sample_l = 16'h7FFF; sample_r = 16'h7FFF; sample_valid = 1'b1; mute = 1'b0;
    run_cycles(512);
    run_until(77);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge mclk);
    run_cycles(2);
    rst = 1'b0;
    run_cycles(768);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
